// File: rtl/dpram_32x32_cb.sv
// Dual-port 32x32 synchronous SRAM model with active-low macro-style controls.
// Latency: read data lands in the port output register one clk edge after the access.
// Backpressure: none; both ports accept an access every cycle with no stalls.
module dpram_32x32_cb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32   // must equal 2**ADDR_W so every address is in range
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic              CEB1,
  input  logic              CSB1,
  input  logic              WEB1,
  input  logic              OEB1,
  input  logic [DATA_W-1:0] I1,
  output logic [DATA_W-1:0] O1,
  input  logic [ADDR_W-1:0] A2,
  input  logic              CEB2,
  input  logic              CSB2,
  input  logic              WEB2,
  input  logic              OEB2,
  input  logic [DATA_W-1:0] I2,
  output logic [DATA_W-1:0] O2
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q1;
  logic [DATA_W-1:0] q2;

  // A port acts only when both enables are solidly low. Equality against
  // explicit constants means an X/Z control evaluates as not-true, so the
  // port behaves as idle rather than corrupting state.
  logic wr1, rd1, wr2, rd2;
  assign wr1 = (CEB1 == 1'b0) && (CSB1 == 1'b0) && (WEB1 == 1'b0);
  assign rd1 = (CEB1 == 1'b0) && (CSB1 == 1'b0) && (WEB1 == 1'b1);
  assign wr2 = (CEB2 == 1'b0) && (CSB2 == 1'b0) && (WEB2 == 1'b0);
  assign rd2 = (CEB2 == 1'b0) && (CSB2 == 1'b0) && (WEB2 == 1'b1);

  // Storage and output registers. Reads sample the array before this edge's
  // writes land (read-before-write). Port 2 is written first so that a
  // same-address port 1 write overrides it (port 1 wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      q1 <= '0;
      q2 <= '0;
    end else begin
      if (rd1) begin
        q1 <= mem[A1];
      end
      if (rd2) begin
        q2 <= mem[A2];
      end
      if (wr2) begin
        mem[A2] <= I2;
      end
      if (wr1) begin
        mem[A1] <= I1;
      end
    end
  end

  // Output enable gates the registered data onto the pins with no clocking.
  assign O1 = OEB1 ? {DATA_W{1'bz}} : q1;
  assign O2 = OEB2 ? {DATA_W{1'bz}} : q2;

endmodule

// File: tb/tb_dpram_32x32_cb.sv
`timescale 1ns/100ps
module tb_dpram_32x32_cb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a1, a2;
  logic        ceb1, csb1, web1, oeb1;
  logic        ceb2, csb2, web2, oeb2;
  logic [31:0] i1, i2;
  wire  [31:0] o1, o2;

  int tests;
  int fails;

  dpram_32x32_cb #(.ADDR_W(5), .DATA_W(32), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .A1(a1), .CEB1(ceb1), .CSB1(csb1), .WEB1(web1), .OEB1(oeb1), .I1(i1), .O1(o1),
    .A2(a2), .CEB2(ceb2), .CSB2(csb2), .WEB2(web2), .OEB2(oeb2), .I2(i2), .O2(o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [32];
  logic [31:0] m_q1, m_q2;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] r1, r2;
    logic p1_act, p2_act;
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) m_mem[k] = 32'h0;
      m_q1 = 32'h0;
      m_q2 = 32'h0;
    end else begin
      p1_act = (ceb1 == 1'b0) && (csb1 == 1'b0);
      p2_act = (ceb2 == 1'b0) && (csb2 == 1'b0);
      // both reads see the array as it stood before this edge
      r1 = m_mem[a1];
      r2 = m_mem[a2];
      if (p1_act && web1) m_q1 = r1;
      if (p2_act && web2) m_q2 = r2;
      // port 1 applied last so it wins an address clash
      if (p2_act && !web2) m_mem[a2] = i2;
      if (p1_act && !web1) m_mem[a1] = i1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // A released bus reads as all-Z on a four-state simulator; a two-state
  // simulator resolves the undriven net to 0, so either is accepted.
  task automatic chk_z(input string nm, input logic [31:0] act);
    tests++;
    if (!(act === 32'hzzzzzzzz || act === 32'h0)) begin
      fails++;
      $display("FAIL %s: got %h, expected high-Z at %0t", nm, act, $time);
    end
  endtask

  // compare process: outputs against the model on every falling edge
  always @(negedge clk) begin
    if (oeb1) chk_z("cmp_o1_z", o1); else chk("cmp_o1", o1, m_q1);
    if (oeb2) chk_z("cmp_o2_z", o2); else chk("cmp_o2", o2, m_q2);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle1(); ceb1 = 1'b1; csb1 = 1'b1; web1 = 1'b1; endtask
  task automatic idle2(); ceb2 = 1'b1; csb2 = 1'b1; web2 = 1'b1; endtask
  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    ceb1 = 1'b0; csb1 = 1'b0; web1 = 1'b0; a1 = a; i1 = d;
  endtask
  task automatic wr2(input logic [4:0] a, input logic [31:0] d);
    ceb2 = 1'b0; csb2 = 1'b0; web2 = 1'b0; a2 = a; i2 = d;
  endtask
  task automatic rd1(input logic [4:0] a);
    ceb1 = 1'b0; csb1 = 1'b0; web1 = 1'b1; a1 = a;
  endtask
  task automatic rd2(input logic [4:0] a);
    ceb2 = 1'b0; csb2 = 1'b0; web2 = 1'b1; a2 = a;
  endtask
  // one clock edge, then return both ports to idle 2ns later
  task automatic tick();
    @(posedge clk);
    #2;
    idle1();
    idle2();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a1 = '0; a2 = '0; i1 = '0; i2 = '0;
    idle1(); idle2();
    oeb1 = 1'b0; oeb2 = 1'b0;

    // reset held low
    repeat (3) @(posedge clk);
    #2;
    chk("rst_o1", o1, 32'h0);
    chk("rst_o2", o2, 32'h0);
    rst_n = 1'b1;

    // first reads after release return cleared words
    rd1(5'd13); rd2(5'd31); tick();
    chk("post_rst_rd1", o1, 32'h0);
    chk("post_rst_rd2", o2, 32'h0);

    // basic write then cross-port and same-port read
    wr1(5'd5, 32'hDEADBEEF); tick();
    rd2(5'd5); tick();
    chk("basic_rd2", o2, 32'hDEADBEEF);
    rd1(5'd5); tick();
    chk("basic_rd1", o1, 32'hDEADBEEF);

    // output-enable gating with no clock edge
    wr1(5'd4, 32'h12345678); tick();
    rd1(5'd4); tick();
    oeb1 = 1'b1; #1;
    chk_z("oe_off_z", o1);
    oeb1 = 1'b0; #1;
    chk("oe_on", o1, 32'h12345678);

    // a write leaves the port's output register alone
    wr1(5'd3, 32'h33333333); tick();
    chk("wr_holds_o1", o1, 32'h12345678);

    // disabled port writes are ignored
    wr1(5'd3, 32'hFFFFFFFF); ceb1 = 1'b1; tick();
    wr1(5'd3, 32'hFFFFFFFF); csb1 = 1'b1; tick();
    rd1(5'd3); tick();
    chk("ce_cs_block", o1, 32'h33333333);

    // write-write collision: port 1 wins; double read sees same word
    wr1(5'd7, 32'hAAAA0001); wr2(5'd7, 32'hBBBB0002); tick();
    rd1(5'd7); rd2(5'd7); tick();
    chk("ww_rd1", o1, 32'hAAAA0001);
    chk("ww_rd2", o2, 32'hAAAA0001);

    // read/write collision: reader gets old data, new data next cycle
    wr1(5'd9, 32'h11111111); tick();
    rd2(5'd9); wr1(5'd9, 32'h22222222); tick();
    chk("rw_old", o2, 32'h11111111);
    rd2(5'd9); tick();
    chk("rw_new", o2, 32'h22222222);

    // independent ports: port 2 trails port 1's writes by one address
    for (int n = 0; n < 32; n++) begin
      wr1(n[4:0], 32'h100 + n);
      if (n >= 1) rd2(5'(n - 1));
      tick();
      if (n >= 1) chk("sweep_rd2", o2, 32'h100 + (n - 1));
    end
    rd2(5'd31); tick();
    chk("sweep_last", o2, 32'h11F);

    // async reset pulse between edges
    #1 rst_n = 1'b0;
    #1;
    chk("arst_o1", o1, 32'h0);
    chk("arst_o2", o2, 32'h0);
    rst_n = 1'b1;
    for (int n = 0; n < 32; n++) begin
      rd1(n[4:0]); rd2(5'(31 - n)); tick();
      chk("arst_mem1", o1, 32'h0);
      chk("arst_mem2", o2, 32'h0);
    end

    repeat (2) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
